// File: rtl/qsys_led_st_pkg.sv
// qsys_led_st_pkg
// Shared definitions for the Avalon-ST packet arbiter slice:
//   arb_state_t : arbiter FSM state encoding
//   clog2w()    : index width helper, never narrower than 1 bit
package qsys_led_st_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qsys_led_rr_pick.sv
// qsys_led_rr_pick
// Rotating-priority first-set search (purely combinational).
// Ports:
//   req   [N]        : request vector
//   ptr   [clog2w(N)]: index with highest priority this cycle
//   found            : at least one request is set
//   idx   [clog2w(N)]: first set request scanning ptr, ptr+1, ... mod N
module qsys_led_rr_pick
    import qsys_led_st_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [clog2w(N)-1:0] ptr,
    output logic                 found,
    output logic [clog2w(N)-1:0] idx
);

    localparam int PW = clog2w(N);
    localparam logic [PW:0] NW = (PW+1)'(N);

    logic [PW:0] w_pos;

    // Scan from the farthest position back to ptr so the last hit
    // written is the one closest to ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (PW+1)'(k);
            if (w_pos >= NW) begin
                w_pos = w_pos - NW;
            end
            if (req[w_pos[PW-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/qsys_led_st_pkt_arbiter.sv
// qsys_led_st_pkt_arbiter
// Merges NUM_IN Avalon-ST packet sources into one stream. Whole packets
// are granted round-robin; the granted source owns the output until its
// eop beat is accepted.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   in_valid/in_ready [NUM_IN]: per-source handshake
//   in_data [NUM_IN*DATA_W]   : source i at [i*DATA_W +: DATA_W]
//   in_startofpacket/in_endofpacket [NUM_IN]: per-source framing
//   out_valid/out_ready       : merged handshake
//   out_data, out_startofpacket, out_endofpacket: merged beat
//   out_channel [CHAN_W]      : index of the source of the beat
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_ARB  | no owner; pick next requester from ptr, all in_ready low
// ST_LOCK | source r_g owns the output until its eop beat is accepted
module qsys_led_st_pkt_arbiter
    import qsys_led_st_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int CHAN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHAN_W-1:0]        out_channel
);

    localparam int PW = clog2w(NUM_IN);
    localparam logic [PW-1:0] LAST_G = PW'(NUM_IN - 1);

    arb_state_t        r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_g;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_sop;
    logic              r_out_eop;
    logic [CHAN_W-1:0] r_out_channel;

    logic              w_found;
    logic [PW-1:0]     w_idx;
    logic [NUM_IN-1:0] w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_data;
    logic              w_sop;
    logic              w_eop;

    qsys_led_rr_pick #(
        .N (NUM_IN)
    ) u_pick (
        .req   (in_valid),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Mux the granted source; only it may see ready, and only when the
    // output register is empty or being drained this cycle.
    always_comb begin
        w_in_ready = '0;
        w_data     = '0;
        w_sop      = 1'b0;
        w_eop      = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (PW'(i) == r_g) begin
                w_data = in_data[i*DATA_W +: DATA_W];
                w_sop  = in_startofpacket[i];
                w_eop  = in_endofpacket[i];
                if (reset_n && (r_state == ST_LOCK)) begin
                    w_in_ready[i] = out_ready | ~r_out_valid;
                end
            end
        end
        w_accept = |(w_in_ready & in_valid);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_ARB;
            r_ptr         <= '0;
            r_g           <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_channel <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_found) begin
                        r_g     <= w_idx;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_accept && w_eop) begin
                        r_state <= ST_ARB;
                        r_ptr   <= (r_g == LAST_G) ? '0 : r_g + 1'b1;
                    end
                end
                default: r_state <= ST_ARB;
            endcase

            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= w_data;
                r_out_sop     <= w_sop;
                r_out_eop     <= w_eop;
                r_out_channel <= CHAN_W'(r_g);
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign in_ready          = w_in_ready;
    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_channel       = r_out_channel;

endmodule

// File: doc/qsys_led_st_pkt_arbiter.md
QSYS_LED_ST_PKT_ARBITER -- requirements
Module: qsys_led_st_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 4, meaning the number of Avalon-ST packet sources, legal range 2..8.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the symbol width in bits.
REQ-003 The block SHALL have parameter CHAN_W, default 8, meaning the out_channel width in bits; CHAN_W >= clog2(NUM_IN).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, NUM_IN bits: per-source beat valid.
REQ-007 The block SHALL have port in_ready, output, NUM_IN bits: per-source beat ready.
REQ-008 The block SHALL have port in_data, input, NUM_IN*DATA_W bits: source i occupies bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have ports in_startofpacket and in_endofpacket, each input, NUM_IN bits: per-source packet framing.
REQ-010 The block SHALL have port out_valid, output, 1 bit: merged beat valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-012 The block SHALL have ports out_data (output, DATA_W), out_startofpacket (output, 1) and out_endofpacket (output, 1): the merged beat.
REQ-013 The block SHALL have port out_channel, output, CHAN_W bits: the index of the source that produced the beat, zero-extended.

Function
REQ-014 The FSM SHALL have two states: ARB (no source owns the output) and LOCK (source g owns the output until its eop beat is accepted).
REQ-015 In ARB with any in_valid set, the block SHALL select the first set bit scanning g = ptr, ptr+1, ... modulo NUM_IN, latch g, and enter LOCK on the next cycle.
REQ-016 In ARB, every in_ready bit SHALL be 0, so the arbitration cycle costs exactly one bubble per packet.
REQ-017 In LOCK, in_ready[g] SHALL equal (out_ready | ~out_valid), and every other in_ready bit SHALL be 0.
REQ-018 A beat SHALL be accepted from source g when in_valid[g] & in_ready[g]; out_data, sop, eop and out_channel = g are then registered and out_valid is set on the next edge, giving a latency of 1 cycle.
REQ-019 out_valid SHALL clear on an edge where out_ready = 1 and no new beat is accepted; output registers SHALL hold while out_valid & ~out_ready.
REQ-020 On acceptance of a beat with in_endofpacket[g] = 1, the FSM SHALL return to ARB and set ptr = (g+1) mod NUM_IN.
REQ-021 A single-beat packet (sop = eop = 1) SHALL follow the same rule as REQ-020.
REQ-022 A beat accepted in LOCK with sop = 1 mid-packet SHALL be passed through unchanged; the lock persists until eop.
REQ-023 A source whose first beat lacks sop SHALL still be granted and passed through; framing is not checked.
REQ-024 Deassertion of in_valid[g] in LOCK SHALL NOT release the lock.
REQ-025 Non-granted sources SHALL be held off for as long as the lock lasts, including indefinitely if no eop arrives.
REQ-026 No beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-027 The output stream SHALL contain only whole packets, never interleaved.

Reset
REQ-028 While reset_n = 0 at an edge, the block SHALL force: state = ARB, ptr = 0, g = 0, out_valid = 0, out_data = 0, out_startofpacket = 0, out_endofpacket = 0, out_channel = 0, and all in_ready bits = 0.
REQ-029 A reset asserted mid-packet SHALL abandon the packet without emitting a closing eop.
REQ-030 The first cycle after reset release SHALL be ARB.

Structure
REQ-031 The state encoding and the clog2 width helper SHALL live in a shared package, qsys_led_st_pkg.
REQ-032 The rotating-priority first-set search SHALL be a combinational sub-module, qsys_led_rr_pick, with parameter N, inputs req[N] and ptr, and outputs found and idx.
REQ-033 All other logic SHALL reside in the top module, with one sequential process and one combinational process.

Verification
REQ-034 Bench case: only source 2 sends a 3-beat packet 0x11, 0x22, 0x33 with out_ready = 1 -> out_channel = 2 on all three beats, sop on 0x11, eop on 0x33, first out_valid 2 cycles after in_valid.
REQ-035 Bench case: all 4 sources continuously valid with 2-beat packets -> channel order 0,1,2,3,0; beats never interleaved.
REQ-036 Bench case: out_ready toggled 1,0,0,1 during a 4-beat packet 0xA0..0xA3 -> all four beats appear in order, each exactly once, and output is stable while stalled.
REQ-037 Bench case: source 1 sends a single-beat packet (sop = eop = 1, data 0x5A) while source 3 is also valid -> 0x5A on channel 1, then source 3 is granted next with ptr = 2.
REQ-038 Bench case: reset_n driven low for 1 cycle after beat 2 of a 4-beat packet from source 0 -> out_valid = 0 and in_ready = 0 during reset; the next grant starts from ptr = 0.
REQ-039 Bench case: source 0 locked and its in_valid dropped for 5 cycles while source 1 is valid -> in_ready[1] stays 0 until source 0's eop is accepted.
